// File: rtl/stepper_phase_decoder_pkg.sv
// Shared constants for the stepper phase decoder: ring patterns, pattern
// lookup, FSM state type and ring-distance codes.
package stepper_pkg;

  // Half-step ring, index 0..7, bit3=A .. bit0=D
  localparam logic [3:0] PH_0   = 4'b1000;
  localparam logic [3:0] PH_1   = 4'b1100;
  localparam logic [3:0] PH_2   = 4'b0100;
  localparam logic [3:0] PH_3   = 4'b0110;
  localparam logic [3:0] PH_4   = 4'b0010;
  localparam logic [3:0] PH_5   = 4'b0011;
  localparam logic [3:0] PH_6   = 4'b0001;
  localparam logic [3:0] PH_7   = 4'b1001;
  localparam logic [3:0] PH_OFF = 4'b0000;

  // Ring distance (new_idx - ref_idx) mod 8
  localparam logic [2:0] DELTA_NONE     = 3'd0;
  localparam logic [2:0] DELTA_FWD_HALF = 3'd1;
  localparam logic [2:0] DELTA_FWD_FULL = 3'd2;
  localparam logic [2:0] DELTA_REV_FULL = 3'd6;
  localparam logic [2:0] DELTA_REV_HALF = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK  = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

  // Returns {valid, idx[2:0]}; valid is 0 for de-energized and illegal patterns
  function automatic logic [3:0] phase_to_idx(input logic [3:0] pat);
    logic [3:0] res;
    case (pat)
      PH_0:    res = {1'b1, 3'd0};
      PH_1:    res = {1'b1, 3'd1};
      PH_2:    res = {1'b1, 3'd2};
      PH_3:    res = {1'b1, 3'd3};
      PH_4:    res = {1'b1, 3'd4};
      PH_5:    res = {1'b1, 3'd5};
      PH_6:    res = {1'b1, 3'd6};
      PH_7:    res = {1'b1, 3'd7};
      default: res = 4'b0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/stepper_phase_decoder_phase_glitch_filter.sv
// Two-flop synchronizer followed by a stability filter: a pattern is
// accepted once it has been seen on FILT_LEN consecutive synchronized
// samples and differs from the previously accepted pattern.
module phase_glitch_filter
  import stepper_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] phase_in,
  output logic [3:0] pat_o,
  output logic       acc_o
);

  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] FL_V = CW'(FILT_LEN);

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_cand;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_pat;
  logic          r_acc;
  logic [CW-1:0] w_cnt_next;
  logic          w_fire;

  // Run length of the current synchronized candidate, capped at FILT_LEN
  always_comb begin
    w_cnt_next = r_cnt;
    if (r_sync2 != r_cand) begin
      w_cnt_next = CW'(1);
    end else if (r_cnt == FL_V) begin
      w_cnt_next = r_cnt;
    end else begin
      w_cnt_next = r_cnt + CW'(1);
    end
  end

  assign w_fire = (w_cnt_next == FL_V) && (r_sync2 != r_pat);

  // Synchronize the pads, track the candidate and emit one accept pulse per new stable pattern
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
      r_cand  <= 4'b0000;
      r_cnt   <= '0;
      r_pat   <= 4'b0000;
      r_acc   <= 1'b0;
    end else begin
      r_sync1 <= phase_in;
      r_sync2 <= r_sync1;
      r_cand  <= r_sync2;
      r_cnt   <= w_cnt_next;
      r_acc   <= w_fire;
      if (w_fire) begin
        r_pat <= r_sync2;
      end else begin
        r_pat <= r_pat;
      end
    end
  end

  assign pat_o = r_pat;
  assign acc_o = r_acc;

endmodule

// File: rtl/stepper_phase_decoder.sv
// Read-only observer of a 4-phase stepper drive: decodes accepted phase
// patterns into position, direction, step pulses, step period, stall and
// fault status.
module stepper_phase_decoder
  import stepper_pkg::*;
#(
  parameter int POS_W     = 16,
  parameter int FILT_LEN  = 4,
  parameter int PER_W     = 20,
  parameter int STALL_CYC = 1000000,
  parameter int ERR_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic [3:0]              phase_in,
  output logic signed [POS_W-1:0] pos_o,
  output logic                    dir_o,
  output logic                    step_o,
  output logic                    step_full_o,
  output logic [PER_W-1:0]        period_o,
  output logic                    period_vld_o,
  output logic                    stall_o,
  output logic                    energized_o,
  output logic                    fault_o,
  output logic [ERR_W-1:0]        err_cnt_o
);

  localparam logic [PER_W-1:0] STALL_V      = PER_W'(STALL_CYC);
  localparam logic [POS_W-1:0] AMT_FWD_HALF = POS_W'(1);
  localparam logic [POS_W-1:0] AMT_FWD_FULL = POS_W'(2);
  localparam logic [POS_W-1:0] AMT_REV_HALF = {POS_W{1'b1}};
  localparam logic [POS_W-1:0] AMT_REV_FULL = {{(POS_W-1){1'b1}}, 1'b0};

  logic [3:0]       w_pat;
  logic             w_acc;
  logic [3:0]       w_info;
  logic             w_valid;
  logic [2:0]       w_idx;
  logic             w_is_zero;
  logic [2:0]       w_delta;
  logic             w_leave;
  logic             w_step_ev;
  logic             w_fault_ev;
  logic             w_step_dir;
  logic             w_step_full;
  logic [POS_W-1:0] w_step_amt;
  logic             w_to_track;
  logic             w_energ_next;
  logic [PER_W-1:0] w_cnt_next;

  state_t           r_state;
  logic [2:0]       r_ref;
  logic             r_first;
  logic [PER_W-1:0] r_cnt;
  logic [PER_W-1:0] r_period;
  logic             r_pvld;
  logic             r_stall;
  logic             r_energ;
  logic             r_step;
  logic             r_dir;
  logic             r_full;
  logic [POS_W-1:0] r_pos;
  logic             r_fault;
  logic [ERR_W-1:0] r_err;

  phase_glitch_filter #(
    .FILT_LEN(FILT_LEN)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .phase_in (phase_in),
    .pat_o    (w_pat),
    .acc_o    (w_acc)
  );

  assign w_info    = phase_to_idx(w_pat);
  assign w_valid   = w_info[3];
  assign w_idx     = w_info[2:0];
  assign w_is_zero = (w_pat == PH_OFF);
  assign w_delta   = w_idx - r_ref;
  assign w_leave   = w_acc && (w_is_zero || !w_valid);

  // Classify an accepted pattern as a step, a fault or no event
  always_comb begin
    w_step_ev   = 1'b0;
    w_fault_ev  = 1'b0;
    w_step_dir  = 1'b0;
    w_step_full = 1'b0;
    w_step_amt  = '0;
    if (!w_acc) begin
      w_step_ev = 1'b0;
    end else if (w_is_zero) begin
      w_step_ev = 1'b0;
    end else if (!w_valid) begin
      w_fault_ev = 1'b1;
    end else if (r_state == ST_IDLE) begin
      w_step_ev = 1'b0;
    end else begin
      case (w_delta)
        DELTA_NONE: begin
          w_step_ev = 1'b0;
        end
        DELTA_FWD_HALF: begin
          w_step_ev  = 1'b1;
          w_step_dir = 1'b1;
          w_step_amt = AMT_FWD_HALF;
        end
        DELTA_REV_HALF: begin
          w_step_ev  = 1'b1;
          w_step_amt = AMT_REV_HALF;
        end
        DELTA_FWD_FULL: begin
          w_step_ev   = 1'b1;
          w_step_dir  = 1'b1;
          w_step_full = 1'b1;
          w_step_amt  = AMT_FWD_FULL;
        end
        DELTA_REV_FULL: begin
          w_step_ev   = 1'b1;
          w_step_full = 1'b1;
          w_step_amt  = AMT_REV_FULL;
        end
        default: begin
          w_fault_ev = 1'b1;
        end
      endcase
    end
  end

  // Where the FSM goes next and what the inter-step counter becomes
  always_comb begin
    w_to_track   = 1'b0;
    w_energ_next = 1'b0;
    w_cnt_next   = '0;
    if (r_state == ST_IDLE) begin
      w_to_track   = 1'b0;
      w_energ_next = w_acc && w_valid;
    end else begin
      w_to_track   = !w_leave;
      w_energ_next = !w_leave;
    end
    if (!w_to_track) begin
      w_cnt_next = '0;
    end else if (w_step_ev) begin
      w_cnt_next = PER_W'(1);
    end else if (r_state == ST_LOCK) begin
      w_cnt_next = '0;
    end else if (r_cnt == {PER_W{1'b1}}) begin
      w_cnt_next = r_cnt;
    end else begin
      w_cnt_next = r_cnt + PER_W'(1);
    end
  end

  // FSM with its registered step, period, stall and energized outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ref    <= 3'd0;
      r_first  <= 1'b0;
      r_cnt    <= '0;
      r_period <= '0;
      r_pvld   <= 1'b0;
      r_stall  <= 1'b0;
      r_energ  <= 1'b0;
      r_step   <= 1'b0;
      r_dir    <= 1'b0;
      r_full   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_stall <= w_to_track && (w_cnt_next >= STALL_V);
      r_energ <= w_energ_next;
      r_step  <= w_step_ev;
      r_pvld  <= w_step_ev && !r_first;
      if (w_step_ev) begin
        r_dir   <= w_step_dir;
        r_full  <= w_step_full;
        r_first <= 1'b0;
        if (!r_first) begin
          r_period <= r_cnt;
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (w_acc && w_valid) begin
            r_state <= ST_LOCK;
            r_ref   <= w_idx;
            r_first <= 1'b1;
          end
        end
        ST_LOCK, ST_TRACK: begin
          if (w_leave) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_TRACK;
            if (w_acc) begin
              r_ref <= w_idx;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Position and fault bookkeeping; clear takes priority over a coincident event
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos   <= '0;
      r_fault <= 1'b0;
      r_err   <= '0;
    end else if (clr) begin
      r_pos   <= '0;
      r_fault <= 1'b0;
      r_err   <= '0;
    end else begin
      if (w_step_ev) begin
        r_pos <= r_pos + w_step_amt;
      end
      if (w_fault_ev) begin
        r_fault <= 1'b1;
        if (r_err != {ERR_W{1'b1}}) begin
          r_err <= r_err + ERR_W'(1);
        end
      end
    end
  end

  assign pos_o        = r_pos;
  assign dir_o        = r_dir;
  assign step_o       = r_step;
  assign step_full_o  = r_full;
  assign period_o     = r_period;
  assign period_vld_o = r_pvld;
  assign stall_o      = r_stall;
  assign energized_o  = r_energ;
  assign fault_o      = r_fault;
  assign err_cnt_o    = r_err;

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Bench for stepper_phase_decoder: directed phase sequences, a per-cycle
// comparison against a behavioural model, and literal spot checks.
module tb_stepper_phase_decoder;

  localparam int FILT  = 4;
  localparam int STALL = 100;
  localparam int MAXP  = (1 << 20) - 1;
  localparam int MI = 0, ML = 1, MT = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               clr;
  logic [3:0]         phase_in;
  logic signed [15:0] pos_o;
  logic               dir_o, step_o, step_full_o, period_vld_o, stall_o, energized_o, fault_o;
  logic [19:0]        period_o;
  logic [7:0]         err_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] ring [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};

  stepper_phase_decoder #(
    .POS_W(16), .FILT_LEN(FILT), .PER_W(20), .STALL_CYC(STALL), .ERR_W(8)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .phase_in(phase_in),
    .pos_o(pos_o), .dir_o(dir_o), .step_o(step_o), .step_full_o(step_full_o),
    .period_o(period_o), .period_vld_o(period_vld_o), .stall_o(stall_o),
    .energized_o(energized_o), .fault_o(fault_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ring_pos(input logic [3:0] p);
    for (int i = 0; i < 8; i++) begin
      if (ring[i] == p) return i;
    end
    return -1;
  endfunction

  // ---------------- behavioural model ----------------
  bit         m_valid = 0;
  int         m_edge  = 0;
  int         m_st, m_ref, m_t0;
  bit         m_first;
  logic [15:0] m_pos;
  logic [19:0] m_per;
  logic [7:0]  m_err;
  logic       m_dir, m_full, m_step, m_pvld, m_stall, m_fault;
  logic [3:0] m_d1, m_d2, m_last, m_accp;
  logic [3:0] m_fh [FILT];
  bit         m_acc;

  always @(posedge clk) begin
    int idx, d, amt, v;
    bit stp, flt, all_eq;
    logic [3:0] fin;
    m_edge++;
    if (rst) begin
      m_valid = 1; m_st = MI; m_ref = 0; m_t0 = m_edge; m_first = 0;
      m_pos = '0; m_per = '0; m_err = '0;
      m_dir = 0; m_full = 0; m_step = 0; m_pvld = 0; m_stall = 0; m_fault = 0;
      m_d1 = '0; m_d2 = '0; m_last = '0; m_accp = '0; m_acc = 0;
      for (int i = 0; i < FILT; i++) m_fh[i] = '0;
    end else begin
      stp = 0; flt = 0; amt = 0; m_pvld = 0;
      if (m_acc) begin
        idx = ring_pos(m_accp);
        if (m_accp == 4'b0000) begin
          m_st = MI;
        end else if (idx < 0) begin
          flt = 1; m_st = MI;
        end else if (m_st == MI) begin
          m_st = ML; m_ref = idx; m_first = 1;
        end else begin
          d = (idx - m_ref + 8) % 8;
          if (d == 1) amt = 1;
          else if (d == 7) amt = -1;
          else if (d == 2) amt = 2;
          else if (d == 6) amt = -2;
          else if (d != 0) flt = 1;
          stp = (amt != 0);
          if (stp) begin
            if (!m_first) begin
              v = m_edge - 1 - m_t0;
              m_per = 20'((v > MAXP) ? MAXP : v);
              m_pvld = 1;
            end
            m_first = 0;
            m_t0 = m_edge - 1;
            m_dir = (amt > 0);
            m_full = (amt == 2 || amt == -2);
          end else if (m_st == ML) begin
            m_t0 = m_edge;
          end
          m_ref = idx; m_st = MT;
        end
      end else if (m_st == ML) begin
        m_st = MT; m_t0 = m_edge;
      end
      m_step = stp;
      if (clr) begin
        m_pos = '0; m_err = '0; m_fault = 0;
      end else begin
        if (stp) m_pos = m_pos + 16'(amt);
        if (flt) begin
          m_fault = 1;
          if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end
      end
      m_stall = (m_st == MT) && ((m_edge - m_t0) >= STALL);
      // stability filter on the synchronized stream
      fin = m_d2;
      for (int i = FILT - 1; i > 0; i--) m_fh[i] = m_fh[i-1];
      m_fh[0] = fin;
      all_eq = 1;
      for (int i = 0; i < FILT; i++) if (m_fh[i] != fin) all_eq = 0;
      m_acc = all_eq && (fin != m_last);
      if (m_acc) begin
        m_last = fin; m_accp = fin;
      end
      m_d2 = m_d1;
      m_d1 = phase_in;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model", {13'd0, pos_o, dir_o, step_o, step_full_o, period_o, period_vld_o, stall_o,
                    energized_o, fault_o, err_cnt_o},
                   {13'd0, m_pos, m_dir, m_step, m_full, m_per, m_pvld, m_stall,
                    (m_st != MI), m_fault, m_err});
    end
  end

  task automatic hold(input logic [3:0] p, input int n);
    phase_in = p;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; phase_in = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rst_pos", 64'(pos_o), 64'h0);
    chk("rst_energized", 64'(energized_o), 64'h0);
    chk("rst_err", 64'(err_cnt_o), 64'h0);
    rst = 1'b0;

    // 1) first half step forward
    hold(4'b1000, 10);
    chk("t1_energized", 64'(energized_o), 64'h1);
    phase_in = 4'b1100;
    repeat (6) @(negedge clk);
    chk("t1_no_step_e6", 64'(step_o), 64'h0);
    @(negedge clk);
    chk("t1_step_e7", 64'(step_o), 64'h1);
    chk("t1_pos", {48'd0, pos_o}, 64'h1);
    chk("t1_dir", 64'(dir_o), 64'h1);
    chk("t1_full", 64'(step_full_o), 64'h0);
    chk("t1_no_pvld", 64'(period_vld_o), 64'h0);
    hold(4'b1100, 5);

    // 2) full steps in reverse with period measurement
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hold(4'b1000, 50);
    hold(4'b0001, 50);
    chk("t2_pos1", {48'd0, pos_o}, 64'hFFFE);
    phase_in = 4'b0010;
    repeat (7) @(negedge clk);
    chk("t2_step", 64'(step_o), 64'h1);
    chk("t2_pvld", 64'(period_vld_o), 64'h1);
    chk("t2_period", 64'(period_o), 64'd50);
    chk("t2_pos2", {48'd0, pos_o}, 64'hFFFC);
    chk("t2_dir", 64'(dir_o), 64'h0);
    chk("t2_full", 64'(step_full_o), 64'h1);

    // 3) glitches shorter than the filter length
    hold(4'b0010, 20);
    hold(4'b0011, 1);
    hold(4'b0010, 20);
    chk("t3_pos_g1", {48'd0, pos_o}, 64'hFFFC);
    hold(4'b0011, 3);
    hold(4'b0010, 20);
    chk("t3_pos_g3", {48'd0, pos_o}, 64'hFFFC);
    chk("t3_fault", 64'(fault_o), 64'h0);

    // 4) illegal jump, then illegal pattern
    hold(4'b1000, 20);
    chk("t4_fault", 64'(fault_o), 64'h1);
    chk("t4_err1", 64'(err_cnt_o), 64'h1);
    chk("t4_pos", {48'd0, pos_o}, 64'hFFFC);
    hold(4'b1010, 20);
    chk("t4_err2", 64'(err_cnt_o), 64'h2);
    chk("t4_deenergized", 64'(energized_o), 64'h0);

    // 5) stall detection, then position wrap
    hold(4'b1000, 20);
    phase_in = 4'b1100;
    repeat (7) @(negedge clk);
    chk("t5_step", 64'(step_o), 64'h1);
    repeat (98) @(negedge clk);
    chk("t5_stall_99", 64'(stall_o), 64'h0);
    @(negedge clk);
    chk("t5_stall_100", 64'(stall_o), 64'h1);
    hold(4'b1100, 20);
    phase_in = 4'b0100;
    repeat (7) @(negedge clk);
    chk("t5_step2", 64'(step_o), 64'h1);
    chk("t5_stall_clr", 64'(stall_o), 64'h0);
    chk("t5_period", 64'(period_o), 64'd126);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t5_clr_pos", {48'd0, pos_o}, 64'h0);
    chk("t5_clr_fault", 64'(fault_o), 64'h0);
    for (int i = 1; i <= 16383; i++) begin
      hold(ring[(2 + 2 * i) % 8], 4);
    end
    hold(ring[0], 8);
    chk("t5_pos_7ffe", {48'd0, pos_o}, 64'h7FFE);
    hold(ring[1], 10);
    chk("t5_pos_7fff", {48'd0, pos_o}, 64'h7FFF);
    hold(ring[2], 10);
    chk("t5_pos_wrap", {48'd0, pos_o}, 64'h8000);

    // 6) clear coincident with a step, then reset mid-track
    hold(4'b0001, 10);
    chk("t6_fault_set", 64'(fault_o), 64'h1);
    phase_in = 4'b1001;
    repeat (6) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t6_clr_step", 64'(step_o), 64'h1);
    chk("t6_clr_pos", {48'd0, pos_o}, 64'h0);
    chk("t6_clr_fault", 64'(fault_o), 64'h0);
    chk("t6_clr_err", 64'(err_cnt_o), 64'h0);
    hold(4'b1001, 5);
    phase_in = 4'b1000;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_outputs", {13'd0, pos_o, dir_o, step_o, step_full_o, period_o, period_vld_o,
                           stall_o, energized_o, fault_o, err_cnt_o}, 64'h0);
    rst = 1'b0;
    hold(4'b1000, 12);
    chk("t6_relock", 64'(energized_o), 64'h1);
    hold(4'b1000, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
